// File: rtl/network_encode_pkg.sv
// ============================================================================
//  Module   : network_encode_pkg
//  Purpose  : Shared constants and types for the ASR output encoder and the
//             LED decoder that consumes its one-hot word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package network_encode_pkg;

    localparam int NUM_CLASS = 20;
    localparam int SCORE_W   = 16;
    localparam int IDX_W     = 5;

    // Encoder control states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DECIDE  = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    typedef logic [SCORE_W-1:0]   score_t;
    typedef logic [NUM_CLASS-1:0] onehot_t;
    typedef logic [IDX_W-1:0]     idx_t;

    localparam idx_t IDX_ONE  = idx_t'(1);
    localparam idx_t LAST_IDX = idx_t'(NUM_CLASS - 1);

endpackage

`default_nettype wire

// File: rtl/top2_tracker.sv
// ============================================================================
//  Module   : top2_tracker
//  Purpose  : Tracks the best score and its index (and, when
//             CONFIDENCE_MARGIN_EN is defined, the second-best score) over
//             the beats of one frame. Synchronous clear and frame-start load.
//  Config   : CONFIDENCE_MARGIN_EN - adds the second-best register
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top2_tracker
    import network_encode_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic               update_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [SCORE_W-1:0] best_o,
    output logic [IDX_W-1:0]   best_idx_o
`ifdef CONFIDENCE_MARGIN_EN
    ,
    output logic [SCORE_W-1:0] second_o
`endif
);

    logic [SCORE_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
`ifdef CONFIDENCE_MARGIN_EN
    logic [SCORE_W-1:0] second_q, second_d;
`endif

    // Next best/second: strict compare so equal scores keep the lower index
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
`ifdef CONFIDENCE_MARGIN_EN
        second_d   = second_q;
`endif
        if (clear_i) begin
            best_d     = '0;
            best_idx_d = '0;
`ifdef CONFIDENCE_MARGIN_EN
            second_d   = '0;
`endif
        end else if (load_i) begin
            best_d     = score_i;
            best_idx_d = '0;
`ifdef CONFIDENCE_MARGIN_EN
            second_d   = '0;
`endif
        end else if (update_i) begin
            if (score_i > best_q) begin
                best_d     = score_i;
                best_idx_d = idx_i;
`ifdef CONFIDENCE_MARGIN_EN
                second_d   = best_q;
            end else if (score_i > second_q) begin
                second_d   = score_i;
`endif
            end
        end
    end

    // Tracker registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_q     <= '0;
            best_idx_q <= '0;
`ifdef CONFIDENCE_MARGIN_EN
            second_q   <= '0;
`endif
        end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
`ifdef CONFIDENCE_MARGIN_EN
            second_q   <= second_d;
`endif
        end
    end

    assign best_o     = best_q;
    assign best_idx_o = best_idx_q;
`ifdef CONFIDENCE_MARGIN_EN
    assign second_o   = second_q;
`endif

endmodule

`default_nettype wire

// File: rtl/network_output_encode.sv
// ============================================================================
//  Module   : network_output_encode
//  Purpose  : Winner-take-all scan over serially streamed class scores with a
//             confidence threshold; publishes a held one-hot word, the
//             winning index and a one-cycle valid strobe.
//  Config   : CONFIDENCE_MARGIN_EN - hit also requires best-second >= MARGIN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module network_output_encode
    import network_encode_pkg::*;
#(
    parameter logic [SCORE_W-1:0] THRESHOLD = 16'h8000
`ifdef CONFIDENCE_MARGIN_EN
    ,
    parameter logic [SCORE_W-1:0] MARGIN    = 16'h1000
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 score_valid,
    input  logic                 score_sof,
    input  logic [SCORE_W-1:0]   score_data,
    output logic                 score_ready,
    output logic [NUM_CLASS-1:0] network_encode_output,
    output logic                 encode_valid,
    output logic [IDX_W-1:0]     class_index,
    output logic                 busy
);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CLASS-1:0]   result_q, result_d;
    logic [IDX_W-1:0]       win_idx_q, win_idx_d;
    logic [NUM_CLASS-1:0]   out_q;
    logic [IDX_W-1:0]       cls_q;
    logic                   ev_q;

    logic                   w_accept;
    logic                   w_load;
    logic                   w_update;
    logic                   w_frame_end;
    logic                   w_hit;
    logic [SCORE_W-1:0]     w_best;
    logic [IDX_W-1:0]       w_best_idx;
`ifdef CONFIDENCE_MARGIN_EN
    logic [SCORE_W-1:0]     w_second;
    logic [SCORE_W:0]       w_diff;
`endif

    // A sof beat always (re)starts a frame, even mid-scan
    assign w_accept    = score_valid & score_ready;
    assign w_load      = w_accept & score_sof;
    assign w_update    = w_accept & ~score_sof & (state_q == SCAN);
    assign w_frame_end = w_update & (idx_q == LAST_IDX);

    top2_tracker u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_q == PUBLISH),
        .load_i     (w_load),
        .update_i   (w_update),
        .score_i    (score_data),
        .idx_i      (idx_q),
        .best_o     (w_best),
        .best_idx_o (w_best_idx)
`ifdef CONFIDENCE_MARGIN_EN
        ,
        .second_o   (w_second)
`endif
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_load) state_d = SCAN;
            SCAN:    if (w_frame_end) state_d = DECIDE;
            DECIDE:  state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        score_ready = (state_q == IDLE) || (state_q == SCAN);
        busy        = (state_q != IDLE);
    end

    // Class index counter: class 0 is the sof beat, so a load points at class 1
    always_comb begin
        idx_d = idx_q;
        if (w_load)        idx_d = IDX_ONE;
        else if (w_update) idx_d = w_frame_end ? '0 : idx_q + IDX_ONE;
    end

    // Decision: threshold test (plus margin test when enabled)
    always_comb begin
        w_hit = (w_best >= THRESHOLD);
`ifdef CONFIDENCE_MARGIN_EN
        w_diff = {1'b0, w_best} - {1'b0, w_second};
        w_hit  = w_hit && (w_diff >= {1'b0, MARGIN});
`endif
        result_d  = w_hit ? (onehot_t'(1) << w_best_idx) : '0;
        win_idx_d = w_hit ? w_best_idx : '0;
    end

    // Counter, decision and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            result_q  <= '0;
            win_idx_q <= '0;
            out_q     <= '0;
            cls_q     <= '0;
            ev_q      <= 1'b0;
        end else begin
            idx_q <= idx_d;
            if (state_q == DECIDE) begin
                result_q  <= result_d;
                win_idx_q <= win_idx_d;
            end
            if (state_q == PUBLISH) begin
                out_q <= result_q;
                cls_q <= win_idx_q;
            end
            ev_q <= (state_q == PUBLISH);
        end
    end

    assign network_encode_output = out_q;
    assign class_index           = cls_q;
    assign encode_valid          = ev_q;

endmodule

`default_nettype wire

// File: tb/tb_network_output_encode.sv
// ============================================================================
//  Module   : tb_network_output_encode
//  Purpose  : Self-checking bench for network_output_encode with a frame-level
//             reference model (argmax, sorted second-best, threshold/margin).
//  Config   : CONFIDENCE_MARGIN_EN - expectations follow the margin build
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_network_output_encode;
    import network_encode_pkg::*;

    localparam logic [15:0] TH = 16'h8000;
    localparam logic [15:0] MG = 16'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        score_valid = 1'b0;
    logic        score_sof = 1'b0;
    logic [15:0] score_data = '0;
    logic        score_ready;
    logic [19:0] network_encode_output;
    logic        encode_valid;
    logic [4:0]  class_index;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = -1;
    int dbl = 0;
    int last_acc_cyc = 0;
    logic prev_ev = 1'b0;
    logic [15:0] frame [NUM_CLASS];

    network_output_encode dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .score_valid           (score_valid),
        .score_sof             (score_sof),
        .score_data            (score_data),
        .score_ready           (score_ready),
        .network_encode_output (network_encode_output),
        .encode_valid          (encode_valid),
        .class_index           (class_index),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (encode_valid === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
            if (prev_ev === 1'b1) dbl++;
        end
        prev_ev = encode_valid;
    endtask

    task automatic send_beat(input logic sof, input logic [15:0] d);
        int guard = 0;
        while (score_ready !== 1'b1) begin
            tick();
            guard++;
            if (guard > 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout: score_ready=%b after %0d cycles, want 1", score_ready, guard);
                return;
            end
        end
        score_valid = 1'b1;
        score_sof   = sof;
        score_data  = d;
        tick();
        last_acc_cyc = cyc;
        score_valid = 1'b0;
        score_sof   = 1'b0;
        score_data  = 16'($urandom);
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < NUM_CLASS; i++) begin
            send_beat(i == 0, frame[i]);
            if (i != NUM_CLASS - 1) repeat (gap) tick();
        end
    endtask

    // Reference: first maximum wins; second best is the 2nd entry of the sorted scores
    task automatic model(output logic [19:0] oh, output logic [4:0] ix);
        int bi = 0;
        bit hit;
`ifdef CONFIDENCE_MARGIN_EN
        int s[$];
`endif
        for (int i = 1; i < NUM_CLASS; i++)
            if (frame[i] > frame[bi]) bi = i;
        hit = (frame[bi] >= TH);
`ifdef CONFIDENCE_MARGIN_EN
        for (int i = 0; i < NUM_CLASS; i++) s.push_back(int'(frame[i]));
        s.rsort();
        hit = hit && ((s[0] - s[1]) >= int'(MG));
`endif
        oh = hit ? (20'd1 << bi) : 20'd0;
        ix = hit ? 5'(bi) : 5'd0;
    endtask

    // Called right after the last beat's accepting edge
    task automatic check_frame(input string nm, input logic [19:0] eoh, input logic [4:0] eix);
        int p0 = pulses;
        int k  = last_acc_cyc;
        checks++;
        if (score_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s decide_bubble: ready=%b busy=%b, want ready=0 busy=1", nm, score_ready, busy);
        end
        tick();
        checks++;
        if (score_ready !== 1'b0 || encode_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s publish_bubble: ready=%b ev=%b, want ready=0 ev=0", nm, score_ready, encode_valid);
        end
        tick();
        checks++;
        if (encode_valid !== 1'b1 || network_encode_output !== eoh || class_index !== eix || pulse_cyc != k + 2) begin
            errors++;
            $display("FAIL %s result: ev=%b oh=%h idx=%0d at +%0d, want ev=1 oh=%h idx=%0d at +2",
                     nm, encode_valid, network_encode_output, class_index, pulse_cyc - k, eoh, eix);
        end
        tick();
        checks++;
        if (encode_valid !== 1'b0 || network_encode_output !== eoh || class_index !== eix || score_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s hold: ev=%b oh=%h idx=%0d ready=%b, want ev=0 oh=%h idx=%0d ready=1",
                     nm, encode_valid, network_encode_output, class_index, score_ready, eoh, eix);
        end
        tick();
        checks++;
        if (pulses != p0 + 1) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d, want %0d", nm, pulses - p0, 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (network_encode_output !== 20'd0 || class_index !== 5'd0 || encode_valid !== 1'b0 ||
            busy !== 1'b0 || score_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: oh=%h idx=%0d ev=%b busy=%b ready=%b, want 0 0 0 0 1",
                     network_encode_output, class_index, encode_valid, busy, score_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_winner();
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'h0100;
        frame[7] = 16'hF000;
        send_frame(0);
        check_frame("class7", 20'h00080, 5'd7);
    endtask

    task automatic test_below_threshold();
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'h7FFF;
        send_frame(0);
        check_frame("below_th", 20'h0, 5'd0);
    endtask

    task automatic test_tie();
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'h0000;
        frame[3]  = 16'hC000;
        frame[12] = 16'hC000;
        send_frame(1);
`ifdef CONFIDENCE_MARGIN_EN
        check_frame("tie", 20'h0, 5'd0);
`else
        check_frame("tie", 20'h00008, 5'd3);
`endif
    endtask

    task automatic test_midframe_sof();
        int p_start = pulses;
        send_beat(1'b1, 16'h0200);
        for (int i = 1; i < 9; i++) send_beat(1'b0, (i == 2) ? 16'hFFFF : 16'h0300);
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'($urandom_range(0, 16'h7FFF));
        frame[19] = 16'hFFFF;
        send_frame(0);
        checks++;
        if (pulses != p_start) begin
            errors++;
            $display("FAIL midsof_stray: got %0d pulses, want 0", pulses - p_start);
        end
        check_frame("midsof", 20'h80000, 5'd19);
    endtask

    task automatic test_margin();
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'h0100;
        frame[4]  = 16'h9000;
        frame[13] = 16'h8800;
        send_frame(0);
`ifdef CONFIDENCE_MARGIN_EN
        check_frame("margin", 20'h0, 5'd0);
`else
        check_frame("margin", 20'h00010, 5'd4);
`endif
    endtask

    task automatic test_reset_midframe();
        int p_start = pulses;
        send_beat(1'b1, 16'hF000);
        for (int i = 1; i < 15; i++) send_beat(1'b0, 16'h0400);
        rst_n       = 1'b0;
        score_valid = 1'b1;
        score_data  = 16'h0500;
        tick();
        rst_n       = 1'b1;
        score_valid = 1'b0;
        checks++;
        if (network_encode_output !== 20'd0 || class_index !== 5'd0 || encode_valid !== 1'b0 ||
            busy !== 1'b0 || score_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: oh=%h idx=%0d ev=%b busy=%b ready=%b, want 0 0 0 0 1",
                     network_encode_output, class_index, encode_valid, busy, score_ready);
        end
        repeat (6) tick();
        checks++;
        if (pulses != p_start) begin
            errors++;
            $display("FAIL midreset_pulse: got %0d pulses, want 0", pulses - p_start);
        end
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'($urandom_range(0, 16'h7FFF));
        frame[11] = 16'hE000;
        send_frame(3);
        check_frame("after_reset_gaps", 20'h00800, 5'd11);
    endtask

    task automatic test_random();
        logic [19:0] eoh;
        logic [4:0]  eix;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'($urandom);
            if ($urandom_range(0, 2) == 0)
                frame[$urandom_range(0, NUM_CLASS-1)] = frame[$urandom_range(0, NUM_CLASS-1)];
            if ($urandom_range(0, 3) == 0) begin
                int a = $urandom_range(0, NUM_CLASS-1);
                int b = $urandom_range(0, NUM_CLASS-1);
                frame[a] = 16'hF000;
                frame[b] = 16'($urandom_range(16'hE800, 16'hF000));
            end
            if ($urandom_range(0, 3) == 0) begin
                send_beat(1'b0, 16'hFFFF);
                send_beat(1'b0, 16'hFFFF);
            end
            model(eoh, eix);
            send_frame($urandom_range(0, 2));
            check_frame($sformatf("random%0d", f), eoh, eix);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] eoh;
        logic [4:0]  eix;
        int p_start = pulses;
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'h1000;
        frame[0] = 16'hFF00;
        send_frame(0);
        for (int i = 0; i < NUM_CLASS; i++) frame[i] = 16'($urandom);
        model(eoh, eix);
        send_frame(0);
        check_frame("b2b", eoh, eix);
        checks++;
        if (pulses != p_start + 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, want 2", pulses - p_start);
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_below_threshold();
        test_tie();
        test_midframe_sof();
        test_margin();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        checks++;
        if (dbl != 0) begin
            errors++;
            $display("FAIL ev_consecutive: got %0d double pulses, want 0", dbl);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
